// File: rtl/hamming_pkg.sv
// Shared definitions for the extended Hamming(7,4) SECDED encoder/decoder pair:
// codeword bit positions, error classification codes and decoder FSM encoding.
package hamming_pkg;

    // Codeword bit positions (1-based Hamming position minus one; p0 is overall parity)
    localparam int unsigned P1_IDX = 0;
    localparam int unsigned P2_IDX = 1;
    localparam int unsigned D0_IDX = 2;
    localparam int unsigned P4_IDX = 3;
    localparam int unsigned D1_IDX = 4;
    localparam int unsigned D2_IDX = 5;
    localparam int unsigned D3_IDX = 6;
    localparam int unsigned P0_IDX = 7;

    // Error classification reported with each decoded word
    localparam logic [1:0] ERR_NONE = 2'b00;  // clean word
    localparam logic [1:0] ERR_CORR = 2'b01;  // single-bit error, corrected
    localparam logic [1:0] ERR_DBL  = 2'b10;  // double error, data not trustworthy
    localparam logic [1:0] ERR_P0   = 2'b11;  // only the overall parity bit flipped

    // Decoder FSM encoding; 2'b11 is unused and recovers to IDLE
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CHECK = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational SECDED check: syndrome, error class and corrected dataword
// for one 8-bit extended Hamming(7,4) codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [7:0] i_code,
    output logic [2:0] o_syndrome,
    output logic [1:0] o_err,
    output logic [3:0] o_data
);

    logic       w_s1;
    logic       w_s2;
    logic       w_s4;
    logic       w_pchk;
    logic [2:0] w_syn;
    logic [2:0] w_pos;
    logic [7:0] w_fixed;

    assign w_s1   = i_code[P1_IDX] ^ i_code[D0_IDX] ^ i_code[D1_IDX] ^ i_code[D3_IDX];
    assign w_s2   = i_code[P2_IDX] ^ i_code[D0_IDX] ^ i_code[D2_IDX] ^ i_code[D3_IDX];
    assign w_s4   = i_code[P4_IDX] ^ i_code[D1_IDX] ^ i_code[D2_IDX] ^ i_code[D3_IDX];
    assign w_pchk = ^i_code;
    assign w_syn  = {w_s4, w_s2, w_s1};
    // Syndrome is a 1-based position; only meaningful when nonzero
    assign w_pos  = w_syn - 3'd1;

    // Classify the error and flip the bad bit only for a correctable single error;
    // a double error passes the raw data bits through untouched.
    always_comb begin
        o_err   = ERR_NONE;
        w_fixed = i_code;
        if (w_syn == 3'd0) begin
            o_err = w_pchk ? ERR_P0 : ERR_NONE;
        end else if (w_pchk) begin
            o_err   = ERR_CORR;
            w_fixed = i_code ^ (8'd1 << w_pos);
        end else begin
            o_err = ERR_DBL;
        end
    end

    assign o_syndrome = w_syn;
    assign o_data     = {w_fixed[D3_IDX], w_fixed[D2_IDX], w_fixed[D1_IDX], w_fixed[D0_IDX]};

endmodule

// File: rtl/hamming_secded_decoder.sv
// Sequential SECDED decoder: accepts one codeword per handshake, presents the
// decoded result until consumed, and keeps saturating error counters.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic [2:0]       syndrome,
    output logic [1:0]       err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [7:0]       r_code;
    logic             r_out_valid;
    logic [3:0]       r_data;
    logic [2:0]       r_syndrome;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    logic [2:0]       w_syndrome;
    logic [1:0]       w_err;
    logic [3:0]       w_data;
    logic             w_inc_corr;
    logic             w_inc_uncorr;

    hamming_syndrome u_syndrome (
        .i_code     (r_code),
        .o_syndrome (w_syndrome),
        .o_err      (w_err),
        .o_data     (w_data)
    );

    // Next-state logic: IDLE -> CHECK on accept, CHECK -> HOLD, HOLD -> IDLE on consume
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_state_nxt = in_valid  ? ST_CHECK : ST_IDLE;
            ST_CHECK: w_state_nxt = ST_HOLD;
            ST_HOLD:  w_state_nxt = out_ready ? ST_IDLE : ST_HOLD;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and input capture; the codeword is latched only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && in_valid) begin
                r_code <= code_in;
            end
        end
    end

    // Result registers: loaded once in CHECK, then frozen while out_valid is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_data      <= 4'd0;
            r_syndrome  <= 3'd0;
            r_err       <= ERR_NONE;
        end else begin
            if (r_state == ST_CHECK) begin
                r_out_valid <= 1'b1;
                r_data      <= w_data;
                r_syndrome  <= w_syndrome;
                r_err       <= w_err;
            end else if (r_state == ST_HOLD && out_ready) begin
                r_out_valid <= 1'b0;
            end else if (r_state != ST_HOLD) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign w_inc_corr   = (r_state == ST_CHECK) && ((w_err == ERR_CORR) || (w_err == ERR_P0));
    assign w_inc_uncorr = (r_state == ST_CHECK) && (w_err == ERR_DBL);

    // Saturating error counters; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (w_inc_corr && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + CNT_ONE;
            end
            if (w_inc_uncorr && (r_uncorr_cnt != '1)) begin
                r_uncorr_cnt <= r_uncorr_cnt + CNT_ONE;
            end
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign data_out   = r_data;
    assign syndrome   = r_syndrome;
    assign err        = r_err;
    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder: two instances (default 8-bit and
// 2-bit counters) share one stimulus stream; expectations are hand-computed.
module tb_hamming_secded_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] code_in;
    logic       out_ready;
    logic       clr_cnt;

    logic       in_ready;
    logic       out_valid;
    logic [3:0] data_out;
    logic [2:0] syndrome;
    logic [1:0] err;
    logic [7:0] corr_cnt;
    logic [7:0] uncorr_cnt;

    logic       in_ready2;
    logic       out_valid2;
    logic [3:0] data_out2;
    logic [2:0] syndrome2;
    logic [1:0] err2;
    logic [1:0] corr_cnt2;
    logic [1:0] uncorr_cnt2;

    int n_checks;
    int n_fail;
    int m_corr8;
    int m_uncorr8;
    int m_corr2;
    int m_uncorr2;

    hamming_secded_decoder #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .code_in    (code_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .syndrome   (syndrome),
        .err        (err),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    hamming_secded_decoder #(.CNT_W(2)) dut_c2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .code_in    (code_in),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .data_out   (data_out2),
        .syndrome   (syndrome2),
        .err        (err2),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt2),
        .uncorr_cnt (uncorr_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, need finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_counters();
        check("corr_cnt8",   32'(corr_cnt),    32'(m_corr8));
        check("uncorr_cnt8", 32'(uncorr_cnt),  32'(m_uncorr8));
        check("corr_cnt2",   32'(corr_cnt2),   32'(m_corr2));
        check("uncorr_cnt2", 32'(uncorr_cnt2), 32'(m_uncorr2));
    endtask

    // One full transaction. Inputs change on the falling edge, outputs are sampled there too.
    task automatic run_word(input logic [7:0] code, input logic [3:0] e_data,
                            input logic [2:0] e_syn, input logic [1:0] e_err,
                            input int stall, input bit clr_in_check, input bit early_ready);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        code_in  = code;
        @(negedge clk);
        // accept edge has passed: decoder is in CHECK
        in_valid = 1'b0;
        check("latency_no_valid_yet", 32'(out_valid), 32'd0);
        check("in_ready_check", 32'(in_ready), 32'd0);
        if (clr_in_check) clr_cnt = 1'b1;
        out_ready = early_ready;
        @(negedge clk);
        clr_cnt = 1'b0;
        if (clr_in_check) begin
            m_corr8 = 0; m_uncorr8 = 0; m_corr2 = 0; m_uncorr2 = 0;
        end else if (e_err == 2'b01 || e_err == 2'b11) begin
            m_corr8 = (m_corr8 == 255) ? 255 : m_corr8 + 1;
            m_corr2 = (m_corr2 == 3)   ? 3   : m_corr2 + 1;
        end else if (e_err == 2'b10) begin
            m_uncorr8 = (m_uncorr8 == 255) ? 255 : m_uncorr8 + 1;
            m_uncorr2 = (m_uncorr2 == 3)   ? 3   : m_uncorr2 + 1;
        end
        check("out_valid", 32'(out_valid), 32'd1);
        check("data_out", 32'(data_out), 32'(e_data));
        check("syndrome", 32'(syndrome), 32'(e_syn));
        check("err", 32'(err), 32'(e_err));
        check("data_out_c2", 32'(data_out2), 32'(e_data));
        check_counters();
        for (int i = 0; i < stall; i++) begin
            // a competing producer must not be accepted while the result is held
            in_valid = 1'b1;
            code_in  = 8'h0F;
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_data", 32'(data_out), 32'(e_data));
            check("stall_syndrome", 32'(syndrome), 32'(e_syn));
            check("stall_err", 32'(err), 32'(e_err));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("consumed_out_valid", 32'(out_valid), 32'd0);
        check("consumed_in_ready", 32'(in_ready), 32'd1);
        check_counters();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_corr8   = 0;
        m_uncorr8 = 0;
        m_corr2   = 0;
        m_uncorr2 = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        code_in   = 8'h00;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_syndrome", 32'(syndrome), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check_counters();

        // clean word, single data error, double error, p0-only error
        run_word(8'h55, 4'hB, 3'd0, 2'b00, 0, 1'b0, 1'b0);
        run_word(8'h45, 4'hB, 3'd5, 2'b01, 0, 1'b0, 1'b0);
        run_word(8'h56, 4'hB, 3'd3, 2'b10, 0, 1'b0, 1'b0);
        run_word(8'hD5, 4'hB, 3'd0, 2'b11, 0, 1'b0, 1'b0);
        // other datawords: all-zero clean, all-ones clean, early out_ready
        run_word(8'h00, 4'h0, 3'd0, 2'b00, 0, 1'b0, 1'b1);
        run_word(8'hFF, 4'hF, 3'd0, 2'b00, 0, 1'b0, 1'b0);
        // backpressure for 5 cycles with a competing in_valid
        run_word(8'hDF, 4'hF, 3'd6, 2'b01, 5, 1'b0, 1'b0);

        // standalone clear, then four single errors saturate the 2-bit counter
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        m_corr8 = 0; m_uncorr8 = 0; m_corr2 = 0; m_uncorr2 = 0;
        check_counters();
        run_word(8'h54, 4'hB, 3'd1, 2'b01, 0, 1'b0, 1'b0);
        run_word(8'h15, 4'hB, 3'd7, 2'b01, 0, 1'b0, 1'b0);
        run_word(8'h51, 4'hB, 3'd3, 2'b01, 0, 1'b0, 1'b0);
        run_word(8'hDF, 4'hF, 3'd6, 2'b01, 0, 1'b0, 1'b0);
        check("corr_cnt2_saturated", 32'(corr_cnt2), 32'd3);
        check("corr_cnt8_four", 32'(corr_cnt), 32'd4);

        // clear coinciding with an increment
        run_word(8'h45, 4'hB, 3'd5, 2'b01, 0, 1'b1, 1'b0);

        // build counts, then reset during CHECK
        run_word(8'h56, 4'hB, 3'd3, 2'b10, 0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        code_in  = 8'h45;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_in_check", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_uncorr", 32'(uncorr_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_corr8 = 0; m_uncorr8 = 0; m_corr2 = 0; m_uncorr2 = 0;
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check_counters();
        run_word(8'h55, 4'hB, 3'd0, 2'b00, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
# hamming_secded_decoder

Sequential SECDED decoder for the 8-bit extended Hamming(7,4) codewords produced by the team's Hamming encoder. It accepts one codeword per valid/ready handshake, computes the syndrome and overall parity, and corrects any single-bit error. It returns the 4-bit dataword with a syndrome and error classification, and keeps saturating corrected and uncorrectable error counters. It sits on the receive side of the Hamming link, between the tile I/O sequencer and the result output register.

## Interface
- CNT_W, 8: width of each error counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  codeword presented on code_in
- in_ready  out  1  decoder can accept a codeword
- code_in  in  8  codeword: [0]=p1 [1]=p2 [2]=d0 [3]=p4 [4]=d1 [5]=d2 [6]=d3 [7]=p0 (even parity over [6:0])
- out_valid  out  1  result fields valid
- out_ready  in  1  consumer accepts result
- data_out  out  4  decoded dataword {d3,d2,d1,d0}
- syndrome  out  3  {s4,s2,s1}; nonzero value = 1-based Hamming position
- err  out  2  00 clean, 01 single corrected, 10 double/uncorrectable, 11 p0-only error (data good)
- clr_cnt  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  count of results with err=01 or 11
- uncorr_cnt  out  CNT_W  count of results with err=10

## Operation
- FSM states are IDLE, CHECK and HOLD.
  - IDLE: in_ready=1. On in_valid, capture code_in into code_q and go to CHECK.
  - CHECK: in_ready=0. Register the decode results, set out_valid=1 and go to HOLD.
  - HOLD: out_valid=1 and all result fields are stable. On out_ready, clear out_valid and go to IDLE. Otherwise stay in HOLD.
- Syndrome bits:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - pchk = ^c[7:0]
- Classification:
  - syn=0, pchk=0: err=00.
  - syn≠0, pchk=1: err=01. Flip code bit syn-1, then extract the data.
  - syn≠0, pchk=0: err=10. data_out is the uncorrected extraction {c6,c5,c4,c2}.
  - syn=0, pchk=1: err=11. Data is extracted unchanged.
- Counters update once per result, on the CHECK→HOLD transition.
  - Both counters saturate at all-ones; they do not wrap.
  - clr_cnt takes priority over a same-cycle increment; both counters read 0 the next cycle.
- The default FSM arm and any unused state encoding return to IDLE.

## Timing
- Reset values: in_ready=1 after reset releases (FSM in IDLE). out_valid=0, data_out=0, syndrome=0, err=0, corr_cnt=0, uncorr_cnt=0.
- Latency: codeword accepted at edge N gives out_valid=1 after edge N+1 (2 cycles from accept to result).
- Throughput: one codeword per 3 cycles when out_ready is held high.
- Handshake:
  - Transfer occurs when valid and ready are both high at a rising edge.
  - in_valid while in_ready=0 is ignored. The producer holds the codeword until it is accepted.
  - Result fields do not change while out_valid=1 and out_ready=0.
- out_ready high before out_valid rises has no effect.
- Reset asserted mid-operation aborts the transaction. All outputs return to reset values immediately (asynchronous) and the in-flight codeword is dropped.

## Structure
- Shared package hamming_pkg holds:
  - err code localparams ERR_NONE, ERR_CORR, ERR_DBL, ERR_P0
  - FSM state encoding
  - codeword bit-index constants for p0–p4 and d0–d3, shared with the encoder
- One combinational sub-module, hamming_syndrome.
  - Input: code[7:0].
  - Outputs: syndrome[2:0], err[1:0] and corrected data[3:0].
  - The decoder instantiates it on code_q.
- The top contains the FSM, handshake and counter logic only.

## Test plan
- Clean word: code_in=0x55 → data_out=4'hB, syndrome=0, err=00, out_valid 2 cycles after accept, counters unchanged.
- Single data error: code_in=0x45 (c4 flipped) → data_out=4'hB, syndrome=5, err=01, corr_cnt +1.
- Double error: code_in=0x56 (c0 and c1 flipped) → syndrome=3, err=10, data_out=4'hB (uncorrected), uncorr_cnt +1.
- p0-only error: code_in=0xD5 → data_out=4'hB, syndrome=0, err=11, corr_cnt +1.
- Backpressure: out_ready held low for 5 cycles after out_valid rises.
  - Result fields stay stable and in_ready stays 0.
  - A new in_valid during this time is not accepted.
- Counter edges:
  - With CNT_W=2, 4 single-error words leave corr_cnt=3 (saturated).
  - clr_cnt coinciding with an increment leaves corr_cnt=0.
  - rst_n pulsed during CHECK leaves out_valid=0 and in_ready=1.
